nuc970_bch_encoder: RTL and testbench
=====================================

# nuc970_bch_encoder

Streaming BCH encoder matching the NUC970 NAND ECC format used by `nuc970_decoder`: T=4 over GF(2^15), 60 parity bits per 4288-bit (536-byte) codeword payload (512 data + 24 spare bytes). It accepts payload bytes one per cycle and forwards them unchanged. It then appends the 60-bit parity, MSB first, packed into 8 bytes. It sits on the NAND write path, ahead of the page-program sequencer, and is the producer whose output `nuc970_decoder` consumes.

## Interface
- `T`, 4, correctable bits; parity width = `M*T`
- `M`, 15, GF(2^M) field degree
- `DATA_BYTES`, 536, payload bytes per codeword
- `BITS`, 8, bits per cycle (only 8 supported)
- `clk_in`  in  1  single clock, rising edge
- `rst_n_in`  in  1  asynchronous, active-low reset
- `ce_in`  in  1  clock enable; low = full stall, all state and outputs held
- `start_in`  in  1  qualifies `data_in` as payload byte 0
- `data_in`  in  8  payload byte, MSB = first bit on the wire
- `ready_out`  out  1  high when a new codeword may be started (IDLE)
- `data_out`  out  8  payload byte or parity byte
- `first_out`  out  1  `data_out` holds payload byte 0
- `data_bits`  out  1  `data_out` holds a payload byte
- `ecc_bits`  out  1  `data_out` holds a parity byte
- `last_out`  out  1  `data_out` holds the final parity byte

## Operation
- States: IDLE → DATA → ECC → IDLE.
- IDLE:
  - `ready_out`=1.
  - On `start_in`&`ce_in`: clear the parity register, absorb `data_in`, set the byte counter to 1, go to DATA.
- DATA:
  - Each `ce_in` cycle absorbs `data_in` as the next byte; the source must present a contiguous stream.
  - When the counter reaches `DATA_BYTES`, go to ECC; the parity register is then final.
- ECC:
  - Emits 8 parity bytes on consecutive `ce_in` cycles by shifting the 60-bit register left 8 per byte.
  - Byte 7 carries parity bits [3:0] in `data_out[7:4]`; `data_out[3:0]`=0.
  - After byte 7, go to IDLE.
- Parity: systematic LFSR division of payload·x^60 by g(x), bitwise MSB first, 8 bit-steps per cycle.
  - g(x) = product of the minimal polynomials of α, α³, α⁵, α⁷ in GF(2^15), primitive polynomial x^15+x+1.
  - g(x) has degree 60, bit 60 implicit.
- `start_in` in DATA or ECC aborts the current codeword and restarts as from IDLE. The aborted codeword never asserts `last_out`.
- `start_in` with `ce_in`=0 is ignored.
- Reset value of all outputs is 0; state = IDLE, counter = 0, parity register = 0.
- Reset mid-codeword discards it; no `last_out`.

## Timing
- Payload latency 1 cycle: byte k sampled at edge k appears on `data_out` after edge k, with `data_bits`=1. `first_out`=1 for k=0 only.
- Parity bytes 0..7 appear after edges 536..543, with no bubble after payload byte 535. `ecc_bits`=1 on each; `last_out`=1 on byte 7.
- Throughput: one codeword per 544 `ce_in` cycles.
- `ce_in`=0 freezes all outputs; flags do not repeat as new events. The bench counts beats only on `ce_in`=1.
- `ready_out` rises the cycle after the final parity byte. Back-to-back `start_in` on that cycle is accepted.
- Counter: 10 bits, saturates by state change and never wraps.

## Structure
- Package `nuc970_bch_pkg` holds:
  - the 60-bit `G_POLY` constant, shared with `nuc970_decoder`
  - `PARITY_BITS`=60, `PARITY_BYTES`=8, `DATA_BYTES`=536
  - the state enum
- Sub-module `bch_lfsr_step`: combinational 8-bit-per-cycle LFSR update (parity, byte → next parity), unrolled from single-bit steps. It is reused by any future parallel-width variant.
- Top holds the FSM, counter, output registers and parity shift.

## Test plan
- All 536 bytes 0x00 → 536 payload bytes of 00, then parity 00×8; `last_out` on beat 544.
- Bytes 0..511 = 0xFF, 512..535 = 0x00 → parity D3 2B 9F 9F 24 73 54 C0; `first_out` beat 1 only, `last_out` beat 544.
- Random payload through encoder → `buff` → `nuc970_decoder` → `err_cnt`=0 and all-zero `err_out`. The same run with 4 bits flipped → exactly those 4 bits flagged.
- Random `ce_in`=0 stalls (30% duty) on the 0xFF/0x00 vector → identical byte sequence and parity as without stalls, with outputs held during every stall.
- `start_in` at payload byte 200, then a full codeword → the first codeword has no `last_out`; the second codeword's parity equals the golden model.
- `rst_n_in` low at parity byte 3 → all outputs 0 and `ready_out`=1 after release. The next codeword encodes correctly.

Source files
------------

// File: rtl/nuc970_bch_pkg.sv
// Shared constants for the NUC970 NAND BCH code (T=4 over GF(2^15)).
// G_POLY is derived at elaboration from the field so encoder and decoder
// always agree on the same generator.
package nuc970_bch_pkg;

    localparam int          M_FIELD      = 15;
    localparam int          T_CORR       = 4;
    localparam int          PARITY_BITS  = M_FIELD * T_CORR;
    localparam int          PARITY_BYTES = 8;
    localparam int          DATA_BYTES   = 536;
    // x^15 + x + 1
    localparam logic [15:0] PRIM_POLY    = 16'h8003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ECC  = 2'd2
    } bch_state_e;

    // GF(2^15) multiply, shift-and-add with reduction by PRIM_POLY.
    function automatic logic [14:0] gf_mul(input logic [14:0] a, input logic [14:0] b);
        logic [14:0] r;
        logic [14:0] s;
        r = '0;
        s = a;
        for (int i = 0; i < 15; i++) begin
            if (b[i]) r = r ^ s;
            s = {s[13:0], 1'b0} ^ (s[14] ? PRIM_POLY[14:0] : 15'h0000);
        end
        return r;
    endfunction

    // Minimal polynomial of alpha^j: product of (x + beta) over the 15
    // conjugates beta = alpha^(j*2^i). Coefficients land in GF(2).
    function automatic logic [15:0] min_poly(input int j);
        logic [15:0][14:0] p;
        logic [14:0]       beta;
        logic [15:0]       m;
        beta = 15'd1;
        for (int i = 0; i < j; i++) beta = gf_mul(beta, 15'd2);
        p    = '0;
        p[0] = 15'd1;
        for (int c = 0; c < 15; c++) begin
            for (int k = 15; k > 0; k--) p[k] = gf_mul(beta, p[k]) ^ p[k-1];
            p[0] = gf_mul(beta, p[0]);
            beta = gf_mul(beta, beta);
        end
        m = '0;
        for (int k = 0; k < 16; k++) m[k] = p[k][0];
        return m;
    endfunction

    // g(x) = m1 * m3 * m5 * m7 over GF(2); the x^60 term is implicit.
    function automatic logic [PARITY_BITS-1:0] calc_g_poly();
        logic [PARITY_BITS:0] g;
        logic [PARITY_BITS:0] ng;
        logic [15:0]          m;
        g = 61'd1;
        for (int e = 1; e < 2 * T_CORR; e += 2) begin
            m  = min_poly(e);
            ng = '0;
            for (int i = 0; i < 16; i++)
                if (m[i]) ng = ng ^ (g << i);
            g = ng;
        end
        return g[PARITY_BITS-1:0];
    endfunction

    localparam logic [PARITY_BITS-1:0] G_POLY = calc_g_poly();

endpackage

// File: rtl/nuc970_bch_encoder_lfsr_step.sv
// Combinational byte-wide LFSR update: eight single-bit division steps,
// first bit taken from data_i[7].
module bch_lfsr_step
    import nuc970_bch_pkg::*;
(
    input  logic [PARITY_BITS-1:0] par_i,
    input  logic [7:0]             data_i,
    output logic [PARITY_BITS-1:0] par_o
);

    // Unrolled MSB-first division of the message by g(x).
    always_comb begin
        par_o = par_i;
        for (int b = 7; b >= 0; b--) begin
            par_o = {par_o[PARITY_BITS-2:0], 1'b0}
                  ^ ((data_i[b] ^ par_o[PARITY_BITS-1]) ? G_POLY : '0);
        end
    end

endmodule

// File: rtl/nuc970_bch_encoder.sv
// Streaming NUC970 BCH encoder: forwards 536 payload bytes with one cycle
// of latency, then appends the 60-bit parity as 8 bytes, MSB first.
module nuc970_bch_encoder
    import nuc970_bch_pkg::*;
#(
    parameter int T          = 4,
    parameter int M          = 15,
    parameter int DATA_BYTES = 536,
    parameter int BITS       = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       ce_in,
    input  logic       start_in,
    input  logic [7:0] data_in,
    output logic       ready_out,
    output logic [7:0] data_out,
    output logic       first_out,
    output logic       data_bits,
    output logic       ecc_bits,
    output logic       last_out
);

    if (M * T != PARITY_BITS || BITS != 8 || DATA_BYTES > 1023 || DATA_BYTES < 2) begin : g_bad_cfg
        $error("nuc970_bch_encoder: unsupported configuration");
    end

    localparam logic [9:0] LAST_DATA = 10'(DATA_BYTES - 1);
    localparam logic [9:0] LAST_ECC  = 10'(PARITY_BYTES - 1);

    bch_state_e             state_q, state_d;
    logic [9:0]             cnt_q, cnt_d;
    logic [PARITY_BITS-1:0] par_q, par_d;
    logic [7:0]             data_q, data_d;
    logic                   first_q, first_d;
    logic                   dbit_q, dbit_d;
    logic                   ebit_q, ebit_d;
    logic                   last_q, last_d;
    logic [PARITY_BITS-1:0] lfsr_in;
    logic [PARITY_BITS-1:0] lfsr_out;

    // A start always begins from an empty remainder, even mid-codeword.
    assign lfsr_in = (state_q == ST_DATA && !start_in) ? par_q : '0;

    bch_lfsr_step u_step (
        .par_i  (lfsr_in),
        .data_i (data_in),
        .par_o  (lfsr_out)
    );

    // Next-state: start wins in any state; ce_in low holds everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        data_d  = data_q;
        first_d = first_q;
        dbit_d  = dbit_q;
        ebit_d  = ebit_q;
        last_d  = last_q;
        if (ce_in) begin
            first_d = 1'b0;
            dbit_d  = 1'b0;
            ebit_d  = 1'b0;
            last_d  = 1'b0;
            if (start_in) begin
                state_d = ST_DATA;
                cnt_d   = 10'd1;
                par_d   = lfsr_out;
                data_d  = data_in;
                first_d = 1'b1;
                dbit_d  = 1'b1;
            end else begin
                case (state_q)
                    ST_DATA: begin
                        par_d  = lfsr_out;
                        data_d = data_in;
                        dbit_d = 1'b1;
                        if (cnt_q == LAST_DATA) begin
                            state_d = ST_ECC;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                    ST_ECC: begin
                        data_d = par_q[PARITY_BITS-1 -: 8];
                        par_d  = par_q << 8;
                        ebit_d = 1'b1;
                        if (cnt_q == LAST_ECC) begin
                            last_d  = 1'b1;
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        data_d  = '0;
                    end
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            par_q   <= '0;
            data_q  <= '0;
            first_q <= 1'b0;
            dbit_q  <= 1'b0;
            ebit_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            data_q  <= data_d;
            first_q <= first_d;
            dbit_q  <= dbit_d;
            ebit_q  <= ebit_d;
            last_q  <= last_d;
        end
    end

    assign ready_out = (state_q == ST_IDLE);
    assign data_out  = data_q;
    assign first_out = first_q;
    assign data_bits = dbit_q;
    assign ecc_bits  = ebit_q;
    assign last_out  = last_q;

endmodule

// File: tb/tb_nuc970_bch_encoder.sv
// Scoreboard bench for nuc970_bch_encoder: the driver pushes expected beats,
// a negedge monitor pops and compares. Parity comes from a polynomial
// long-division model using g(x) built from its 60 roots in GF(2^15).
module tb_nuc970_bch_encoder;
    import nuc970_bch_pkg::*;

    localparam int NB    = DATA_BYTES;
    localparam int NBITS = NB * 8;
    localparam int PLEN  = NBITS + PARITY_BITS;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       dbit;
        logic       ebit;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready_out, first_out, data_bits, ecc_bits, last_out;
    logic [7:0] data_out;

    int errors = 0;
    int checks = 0;

    beat_t      exp_q[$];
    logic [7:0] pay[0:NB-1];
    logic [7:0] par_exp[0:7];
    logic       gfull[0:PARITY_BITS];
    bit         poly[0:PLEN-1];

    nuc970_bch_encoder #(.T(4), .M(15), .DATA_BYTES(NB), .BITS(8)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .ce_in     (ce),
        .start_in  (start),
        .data_in   (din),
        .ready_out (ready_out),
        .data_out  (data_out),
        .first_out (first_out),
        .data_bits (data_bits),
        .ecc_bits  (ecc_bits),
        .last_out  (last_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [14:0] gmul(input logic [14:0] a, input logic [14:0] b);
        logic [29:0] prod;
        prod = '0;
        for (int i = 0; i < 15; i++)
            if (b[i]) prod = prod ^ (30'(a) << i);
        for (int d = 29; d >= 15; d--)
            if (prod[d]) prod = prod ^ (30'h8003 << (d - 15));
        return prod[14:0];
    endfunction

    // g(x) = product of (x + r) over all 60 roots alpha^(j*2^i), j=1,3,5,7
    task automatic build_gen();
        logic [14:0] c[0:PARITY_BITS];
        logic [14:0] r;
        int          deg;
        for (int k = 0; k <= PARITY_BITS; k++) c[k] = '0;
        c[0] = 15'd1;
        deg  = 0;
        for (int j = 1; j < 8; j += 2) begin
            r = 15'd1;
            for (int p = 0; p < j; p++) r = gmul(r, 15'd2);
            for (int i = 0; i < 15; i++) begin
                for (int k = deg + 1; k > 0; k--) c[k] = c[k-1] ^ gmul(r, c[k]);
                c[0] = gmul(r, c[0]);
                deg++;
                r = gmul(r, r);
            end
        end
        for (int k = 0; k <= PARITY_BITS; k++) begin
            if (c[k] > 15'd1) begin
                $display("FAIL gen_poly: coefficient %0d = %0h not binary", k, c[k]);
                $fatal(1, "reference generator broken");
            end
            gfull[k] = c[k][0];
        end
    endtask

    // remainder of payload(x) * x^60 mod g(x), first wire bit = highest degree
    task automatic model_parity();
        int deg;
        for (int d = 0; d < PLEN; d++) poly[d] = 1'b0;
        for (int w = 0; w < NBITS; w++) poly[PARITY_BITS + NBITS - 1 - w] = pay[w / 8][7 - (w % 8)];
        for (int d = PLEN - 1; d >= PARITY_BITS; d--)
            if (poly[d])
                for (int j = 0; j <= PARITY_BITS; j++) poly[d - PARITY_BITS + j] ^= gfull[j];
        for (int i = 0; i < 8; i++)
            for (int b = 0; b < 8; b++) begin
                deg = PARITY_BITS - 1 - (8 * i + b);
                par_exp[i][7 - b] = (deg >= 0) ? poly[deg] : 1'b0;
            end
    endtask

    task automatic load_golden();
        logic [63:0] g;
        g = 64'hD32B9F9F247354C0;
        for (int i = 0; i < 8; i++) par_exp[i] = g[63 - 8 * i -: 8];
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input logic st, input logic [7:0] d, input int stall_pct);
        @(negedge clk);
        while (int'($urandom_range(99)) < stall_pct) begin
            ce    = 1'b0;
            start = 1'($urandom_range(1));
            din   = 8'($urandom);
            @(negedge clk);
        end
        ce    = 1'b1;
        start = st;
        din   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ce    = 1'b0;
            start = 1'b0;
        end
    endtask

    // use_model=0 keeps whatever par_exp the caller loaded.
    // abort_at<NB stops after that many payload bytes; n_par limits parity beats.
    task automatic send_cw(input int stall_pct, input bit use_model, input bit exp_ready,
                           input int abort_at, input int n_par);
        for (int w = 0; w < NB; w++) begin
            if (w == abort_at) return;
            drive_beat(w == 0, pay[w], stall_pct);
            if (w == 0) chk("ready_at_start", ready_out, exp_ready);
            if (w == 100) chk("ready_in_data", ready_out, 1'b0);
            exp_q.push_back({pay[w], (w == 0), 1'b1, 1'b0, 1'b0});
        end
        if (use_model) model_parity();
        for (int i = 0; i < n_par; i++) begin
            drive_beat(1'b0, 8'($urandom), stall_pct);
            exp_q.push_back({par_exp[i], 1'b0, 1'b0, 1'b1, (i == 7)});
        end
    endtask

    task automatic fill_random();
        for (int w = 0; w < NB; w++) pay[w] = 8'($urandom);
    endtask

    // ---------------- monitor ----------------
    logic  ce_edge;
    beat_t prev = '0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) ce_edge <= 1'b0;
        else        ce_edge <= ce;

    initial begin : monitor
        beat_t cur;
        beat_t e;
        forever begin
            @(negedge clk);
            cur = {data_out, first_out, data_bits, ecc_bits, last_out};
            if (rst_n) begin
                if (ce_edge) begin
                    if (data_bits || ecc_bits) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_beat", cur, 12'h000);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat{data,first,dbit,ebit,last}", cur, e);
                        end
                    end else begin
                        chk("idle_flags", {first_out, last_out}, 2'b00);
                    end
                end else begin
                    chk("stall_hold", cur, prev);
                end
            end
            prev = cur;
        end
    end

    initial begin : timeout
        #5000000;
        $display("FAIL timeout: simulation did not finish, %0d checks done", checks);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [7:0] saved[0:7];
        build_gen();

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {data_out, first_out, data_bits, ecc_bits, last_out}, 12'h000);
        chk("reset_ready", ready_out, 1'b1);
        rst_n = 1'b1;
        idle(2);

        // all-zero payload -> zero parity
        for (int w = 0; w < NB; w++) pay[w] = 8'h00;
        for (int i = 0; i < 8; i++) par_exp[i] = 8'h00;
        send_cw(0, 1'b0, 1'b1, NB, 8);

        // 512 x FF + 24 x 00, back to back with the previous codeword
        for (int w = 0; w < NB; w++) pay[w] = (w < 512) ? 8'hFF : 8'h00;
        load_golden();
        send_cw(0, 1'b0, 1'b1, NB, 8);
        idle(3);

        // the model must agree with the published vector
        for (int i = 0; i < 8; i++) saved[i] = par_exp[i];
        model_parity();
        for (int i = 0; i < 8; i++) chk("model_vs_golden", par_exp[i], saved[i]);

        // same vector with ~30% stalls (start pulses during stalls are ignored)
        load_golden();
        send_cw(30, 1'b0, 1'b1, NB, 8);
        idle(2);

        // random payloads, some stalled
        for (int n = 0; n < 3; n++) begin
            fill_random();
            send_cw((n == 1) ? 20 : 0, 1'b1, 1'b1, NB, 8);
        end
        idle(2);

        // abort at byte 200, then a full codeword
        fill_random();
        send_cw(0, 1'b1, 1'b1, 200, 0);
        fill_random();
        send_cw(0, 1'b1, 1'b0, NB, 8);
        idle(2);

        // reset during parity byte 3
        fill_random();
        send_cw(0, 1'b1, 1'b1, NB, 4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ce    = 1'b0;
        start = 1'b0;
        #1;
        chk("midreset_outputs", {data_out, first_out, data_bits, ecc_bits, last_out}, 12'h000);
        chk("midreset_queue_drained", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {data_out, first_out, data_bits, ecc_bits, last_out}, 12'h000);
        chk("post_reset_ready", ready_out, 1'b1);
        fill_random();
        send_cw(0, 1'b1, 1'b1, NB, 8);
        idle(4);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
